// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle fetch/execute core with a stallable data port,
// run/single-step control, HALT and a retire strobe.
module cpu_core_p #(
  parameter int DATA_W = 8,
  parameter int PC_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              halted,
  output logic              retire,
  output logic [PC_W-1:0]   pc_out
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HLT} state_e;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0] ir_q;
  logic [DATA_W-1:0] rf_q [16];
  logic zf_q, halted_q, retire_q;
  logic [3:0] op, rd;
  logic [DATA_W-1:0] a, b, alu, wb;
  logic go, is_mem, taken, wb_en, zf_en;
  assign op = ir_q[15:12];
  assign rd = ir_q[11:8];
  assign a = rf_q[ir_q[7:4]];
  assign b = rf_q[ir_q[3:0]];
  assign go = run | step;
  assign is_mem = op == 4'h9 || op == 4'hA;
  assign taken = op == 4'hB || (op == 4'hC && zf_q) || (op == 4'hD && !zf_q);
  assign wb_en = op >= 4'h1 && op <= 4'h8;
  assign zf_en = (op >= 4'h2 && op <= 4'h8) || op == 4'hE;
  assign alu = op == 4'h3 ? a - b :
               op == 4'h4 ? a & b :
               op == 4'h5 ? a | b :
               op == 4'h6 ? a ^ b :
               op == 4'h7 ? a << 1 :
               op == 4'h8 ? a >> 1 : a + b;
  assign wb = op == 4'h1 ? DATA_W'(ir_q[7:0]) : alu;
  always_ff @(posedge clk) state_q <= rst ? FETCH : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = go ? EXEC : FETCH;
      EXEC:    state_d = op == 4'hF ? HLT : is_mem ? MEM : FETCH;
      MEM:     state_d = dmem_ready ? FETCH : MEM;
      default: state_d = HLT;
    endcase
  end
  always_comb begin
    dmem_req = state_q == MEM;
    dmem_we = dmem_req && op == 4'hA;
  end
  assign dmem_addr = b;
  assign dmem_wdata = a;
  assign imem_addr = pc_q;
  assign pc_out = pc_q;
  assign halted = halted_q;
  assign retire = retire_q;
  // Registers stay untouched during MEM, so address and store data hold steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      ir_q <= '0;
      zf_q <= 1'b0;
      halted_q <= 1'b0;
      retire_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      if (state_q == FETCH && go) ir_q <= imem_data;
      if (state_q == EXEC && !is_mem) begin
        retire_q <= 1'b1;
        if (op == 4'hF) halted_q <= 1'b1;
        else pc_q <= taken ? ir_q[PC_W-1:0] : pc_q + 1'b1;
        if (wb_en) rf_q[rd] <= wb;
        if (zf_en) zf_q <= op == 4'hE ? a == b : alu == '0;
      end
      if (state_q == MEM && dmem_ready) begin
        retire_q <= 1'b1;
        pc_q <= pc_q + 1'b1;
        if (op == 4'h9) rf_q[rd] <= dmem_rdata;
      end
    end
  end
endmodule
